// File: rtl/ni_bus_pkg.sv
// ni_bus_pkg: shared bus states, Wishbone cti/bte codes and round-robin pick helper
package ni_bus_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;
  localparam int RR_MAX = 32;
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req, input int last, input int n);
    logic [RR_MAX-1:0] g;
    int i;
    g = '0;
    for (int k = n; k >= 1; k--) begin
      i = (last + k) % n;
      if (req[i]) begin
        g = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/ni_rr_arbiter.sv
// ni_rr_arbiter: round-robin owner selection with registered one-hot grant held until release
module ni_rr_arbiter
  import ni_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic         busy
);
  localparam int LW = $clog2(N);
  state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;
  logic [RR_MAX-1:0] pick;
  // pick the next requester after last when idle, drop the grant when the owner releases
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    pick = rr_next(RR_MAX'(req), int'(last_q), N);
    if (state_q == IDLE && en && |req) begin
      state_d = BUSY;
      grant_d = pick[N-1:0];
      for (int i = 0; i < N; i++) if (pick[i]) last_d = LW'(i);
    end else if (state_q == BUSY && rel) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  // arbitration state register; last starts at N-1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= LW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
  assign grant = grant_q;
  assign busy = state_q == BUSY;
endmodule

// File: rtl/ni_wb_arbiter.sv
// ni_wb_arbiter: shares one Wishbone slave path between masters with a per-strobe watchdog
module ni_wb_arbiter
  import ni_bus_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]     m_addr,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]     m_data_in,
  input  logic [MASTERS-1:0]                     m_cyc,
  input  logic [MASTERS-1:0]                     m_stb,
  input  logic [MASTERS-1:0]                     m_we,
  input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0]   m_sel,
  input  logic [MASTERS-1:0][2:0]                m_cti,
  input  logic [MASTERS-1:0][1:0]                m_bte,
  output logic [DATA_WIDTH-1:0]                  m_data_out,
  output logic [MASTERS-1:0]                     m_ack,
  output logic [MASTERS-1:0]                     m_err,
  output logic [MASTERS-1:0]                     m_rty,
  output logic [ADDR_WIDTH-1:0]                  s_addr,
  output logic [DATA_WIDTH-1:0]                  s_data_in,
  output logic                                   s_cyc,
  output logic                                   s_stb,
  output logic                                   s_we,
  output logic [DATA_WIDTH/8-1:0]                s_sel,
  output logic [2:0]                             s_cti,
  output logic [1:0]                             s_bte,
  input  logic [DATA_WIDTH-1:0]                  s_data_out,
  input  logic                                   s_ack,
  input  logic                                   s_err,
  input  logic                                   s_rty,
  output logic [MASTERS-1:0]                     grant,
  output logic                                   timeout_evt
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int LW = $clog2(MASTERS);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic busy, wdog_fire, waiting;
  logic [LW-1:0] g;
  logic [WW-1:0] wdog_q, wdog_d;
  ni_rr_arbiter #(.N(MASTERS)) u_arb (
    .clk(clk), .rst(rst), .req(m_cyc), .en(1'b1), .rel(~m_cyc[g]), .grant(grant), .busy(busy)
  );
  // one-hot grant to owner index
  always_comb begin
    g = '0;
    for (int i = 0; i < MASTERS; i++) if (grant[i]) g = LW'(i);
  end
  // owner pass-through, termination routing and watchdog threshold
  always_comb begin
    waiting = busy && m_stb[g] && !s_ack && !s_err;
    wdog_fire = (TIMEOUT != 0) && waiting && wdog_q == WLIM;
    wdog_d = (TIMEOUT != 0) && waiting && !wdog_fire ? wdog_q + 1'b1 : '0;
    s_addr = busy ? m_addr[g] : '0;
    s_data_in = busy ? m_data_in[g] : '0;
    s_cyc = busy && m_cyc[g];
    s_stb = busy && m_stb[g] && !wdog_fire;
    s_we = busy && m_we[g];
    s_sel = busy ? m_sel[g] : SEL_WIDTH'(0);
    s_cti = busy ? m_cti[g] : 3'b000;
    s_bte = busy ? m_bte[g] : 2'b00;
    m_data_out = busy ? s_data_out : '0;
    m_ack = busy && s_ack ? grant : '0;
    m_err = busy && (s_err || wdog_fire) ? grant : '0;
    m_rty = busy && s_rty ? grant : '0;
    timeout_evt = wdog_fire;
  end
  // watchdog counter for the current strobe
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else wdog_q <= wdog_d;
  end
endmodule

// File: tb/tb_ni_wb_arbiter.sv
// tb_ni_wb_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ni_wb_arbiter;
  localparam int M = 2, AW = 32, DW = 32, SW = 4, TO = 4;
  localparam logic [M-1:0] ONE = 1;
  logic clk = 1'b0, rst;
  logic [M-1:0][AW-1:0] m_addr;
  logic [M-1:0][DW-1:0] m_data_in;
  logic [M-1:0] m_cyc, m_stb, m_we;
  logic [M-1:0][SW-1:0] m_sel;
  logic [M-1:0][2:0] m_cti;
  logic [M-1:0][1:0] m_bte;
  logic [DW-1:0] m_data_out;
  logic [M-1:0] m_ack, m_err, m_rty;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data_in, s_data_out;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [SW-1:0] s_sel;
  logic [2:0] s_cti;
  logic [1:0] s_bte;
  logic [M-1:0] grant;
  logic timeout_evt;
  int checks = 0, failures = 0;

  ni_wb_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_data_in(m_data_in), .m_cyc(m_cyc), .m_stb(m_stb),
    .m_we(m_we), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_data_out(m_data_out),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .s_addr(s_addr), .s_data_in(s_data_in),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_data_out(s_data_out), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .grant(grant),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_addr = '0; m_data_in = '0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
    m_cti = '0; m_bte = '0; s_data_out = 32'h1234_5678; s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b0;
    tick(); tick();
    rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL reset_s_ctrl: got %b want 000", {s_cyc, s_stb, s_we}); end
    checks++; if ({m_ack, m_err, m_rty} !== 6'b0) begin failures++; $display("FAIL reset_term: got %b want 000000", {m_ack, m_err, m_rty}); end
    checks++; if (m_data_out !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", m_data_out); end
    checks++; if (timeout_evt !== 1'b0) begin failures++; $display("FAIL reset_evt: got %b want 0", timeout_evt); end
  endtask

  task automatic test_single_read();
    m_cyc = 2'b01; m_stb = 2'b01; m_addr[0] = 32'h0000_1000; m_we = 2'b00; m_sel[0] = 4'hF;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc); end
    tick();
    checks++; if (grant !== 2'b01 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin failures++; $display("FAIL single_grant: grant/cyc/stb got %b/%b/%b want 01/1/1", grant, s_cyc, s_stb); end
    checks++; if (s_addr !== 32'h0000_1000) begin failures++; $display("FAIL single_addr: got %h want 00001000", s_addr); end
    tick(); tick();
    s_ack = 1'b1; s_data_out = 32'hDEAD_BEEF;
    #1;
    checks++; if (m_ack !== 2'b01 || m_err !== 2'b00) begin failures++; $display("FAIL single_ack: ack/err got %b/%b want 01/00", m_ack, m_err); end
    checks++; if (m_data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata: got %h want deadbeef", m_data_out); end
    tick();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    checks++; if (m_ack !== 2'b00 || grant !== 2'b01) begin failures++; $display("FAIL single_hold: ack/grant got %b/%b want 00/01", m_ack, grant); end
    tick();
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin failures++; $display("FAIL single_release: grant/cyc got %b/%b want 00/0", grant, s_cyc); end
    tick();
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; tick(); rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b00;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL simul_first: got %b want 01", grant); end
    m_cyc = 2'b10;
    tick();
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin failures++; $display("FAIL simul_gap: grant/cyc got %b/%b want 00/0", grant, s_cyc); end
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL simul_second: got %b want 10", grant); end
    m_cyc = 2'b00;
    tick();
    m_cyc = 2'b11;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL simul_rotate: got %b want 01", grant); end
    m_cyc = 2'b00;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    m_cyc = 2'b10;
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL b2b_grant: got %b want 10", grant); end
    m_cyc = 2'b11;
    for (int n = 0; n < 3; n++) begin
      m_stb = 2'b10; s_ack = 1'b1; s_data_out = 32'hA0 + n;
      #1;
      checks++; if (grant !== 2'b10 || m_ack !== 2'b10 || m_err !== 2'b00) begin failures++; $display("FAIL b2b_ack%0d: grant/ack/err got %b/%b/%b want 10/10/00", n, grant, m_ack, m_err); end
      tick();
    end
    m_cyc = 2'b01; m_stb = 2'b00; s_ack = 1'b0;
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL b2b_release: got %b want 00", grant); end
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL b2b_waiter: got %b want 01", grant); end
    m_cyc = 2'b00;
    tick(); tick();
  endtask

  task automatic test_timeout(input bit ack_last);
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_err = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4 && ack_last) s_ack = 1'b1;
      #1;
      if (c < 4) begin
        checks++; if (m_err !== 2'b00 || timeout_evt !== 1'b0 || s_stb !== 1'b1) begin failures++; $display("FAIL wdog_pre%0d_%0d: err/evt/stb got %b/%b/%b want 00/0/1", ack_last, c, m_err, timeout_evt, s_stb); end
      end else if (ack_last) begin
        checks++; if (m_ack !== 2'b01 || m_err !== 2'b00 || timeout_evt !== 1'b0) begin failures++; $display("FAIL wdog_ack_wins: ack/err/evt got %b/%b/%b want 01/00/0", m_ack, m_err, timeout_evt); end
      end else begin
        checks++; if (m_err !== 2'b01 || timeout_evt !== 1'b1 || s_stb !== 1'b0 || m_ack !== 2'b00) begin failures++; $display("FAIL wdog_fire: err/evt/stb/ack got %b/%b/%b/%b want 01/1/0/00", m_err, timeout_evt, s_stb, m_ack); end
      end
      tick();
    end
    s_ack = 1'b0;
    #1;
    checks++; if (grant !== 2'b01 || m_err !== 2'b00 || s_stb !== 1'b1) begin failures++; $display("FAIL wdog_after%0d: grant/err/stb got %b/%b/%b want 01/00/1", ack_last, grant, m_err, s_stb); end
    m_cyc = 2'b00; m_stb = 2'b00;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rstmid_grant: got %b want 01", grant); end
    m_cyc = 2'b11; m_stb = 2'b11; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0 || m_ack !== 2'b00 || m_err !== 2'b00) begin failures++; $display("FAIL rstmid_drop: grant/cyc/ack/err got %b/%b/%b/%b want 00/0/00/00", grant, s_cyc, m_ack, m_err); end
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rstmid_prio: got %b want 01", grant); end
    m_cyc = 2'b00; m_stb = 2'b00;
    tick(); tick();
  endtask

  task automatic test_random();
    int owner, last, wd, o, mode;
    bit busy, fire;
    logic [M-1:0] eg;
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    tick();
    rst = 1'b0; owner = -1; last = M - 1; wd = 0; mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 48 == 0) mode = $urandom_range(0, 2);
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(0, 9) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = $urandom_range(0, 3) != 0;
        m_addr[i] = $urandom; m_data_in[i] = $urandom; m_we[i] = $urandom_range(0, 1);
        m_sel[i] = 4'($urandom); m_cti[i] = 3'($urandom); m_bte[i] = 2'($urandom);
      end
      s_ack = mode == 0 ? 1'b0 : $urandom_range(0, 2) == 0;
      s_err = $urandom_range(0, 29) == 0;
      s_rty = $urandom_range(0, 19) == 0;
      s_data_out = $urandom;
      rst = $urandom_range(0, 299) == 0;
      #1;
      busy = owner >= 0;
      o = busy ? owner : 0;
      fire = busy && m_stb[o] && !s_ack && !s_err && wd == TO - 1;
      eg = busy ? ONE << o : '0;
      checks++; if (grant !== eg) begin failures++; $display("FAIL rnd_grant@%0d: got %b want %b", n, grant, eg); end
      checks++; if ({s_cyc, s_stb} !== {busy && m_cyc[o], busy && m_stb[o] && !fire}) begin failures++; $display("FAIL rnd_cycstb@%0d: got %b want %b", n, {s_cyc, s_stb}, {busy && m_cyc[o], busy && m_stb[o] && !fire}); end
      checks++; if ({s_addr, s_data_in, s_we, s_sel, s_cti, s_bte} !== (busy ? {m_addr[o], m_data_in[o], m_we[o], m_sel[o], m_cti[o], m_bte[o]} : 74'b0)) begin failures++; $display("FAIL rnd_fwd@%0d: got %h", n, {s_addr, s_data_in, s_we, s_sel, s_cti, s_bte}); end
      checks++; if ({m_ack, m_err, m_rty} !== {s_ack ? eg : 2'b00, (s_err || fire) ? eg : 2'b00, s_rty ? eg : 2'b00}) begin failures++; $display("FAIL rnd_term@%0d: got %b want %b", n, {m_ack, m_err, m_rty}, {s_ack ? eg : 2'b00, (s_err || fire) ? eg : 2'b00, s_rty ? eg : 2'b00}); end
      checks++; if (m_data_out !== (busy ? s_data_out : 32'h0)) begin failures++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, m_data_out, busy ? s_data_out : 32'h0); end
      checks++; if (timeout_evt !== fire) begin failures++; $display("FAIL rnd_evt@%0d: got %b want %b", n, timeout_evt, fire); end
      @(posedge clk);
      if (rst) begin
        owner = -1; last = M - 1; wd = 0;
      end else if (owner < 0) begin
        wd = 0;
        for (int k = 1; k <= M; k++) begin
          if (owner < 0 && m_cyc[(last + k) % M]) begin
            owner = (last + k) % M; last = owner;
          end
        end
      end else if (!m_cyc[owner]) begin
        owner = -1; wd = 0;
      end else begin
        wd = (m_stb[owner] && !s_ack && !s_err && !fire) ? wd + 1 : 0;
      end
      #1;
    end
    rst = 1'b0; m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
